// File: rtl/pixel_display_out.sv
`default_nettype none
// ============================================================================
// Module   : pixel_display_out
// Purpose  : Display-side sink of the video pipeline. Scales each 16-bit
//            filtered pixel to 8 bits (shift + saturate), buffers it in a
//            FIFO and replays one H_ACTIVE x V_ACTIVE frame with active,
//            h-blank and v-blank timing. Throttles upstream through pause.
// Ports    : clk           - rising-edge clock
//            rst           - asynchronous active-high reset
//            start         - pulse: begin one frame (only honoured in IDLE)
//            pix_in        - 16-bit filtered pixel
//            pix_in_valid  - pix_in qualifier
//            pause         - upstream hold, fifo count >= FIFO_DEPTH-2
//            pix_out       - 8-bit display pixel (holds when not valid)
//            pix_out_valid - pixel valid, active region only
//            hsync         - pulse with column 0 of every line
//            vsync         - pulse with column 0 of line 0
//            busy          - FSM not IDLE
//            frame_done    - pulse after the last v-blank cycle
//            underrun      - sticky, FIFO empty during an active pixel
//            overflow      - sticky, write attempted while FIFO full
// Revision : 1.0 - initial release
// ============================================================================
module pixel_display_out #(
  parameter int H_ACTIVE   = 8,
  parameter int V_ACTIVE   = 8,
  parameter int H_BLANK    = 2,
  parameter int V_BLANK    = 3,
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] pix_in,
  input  logic        pix_in_valid,
  output logic        pause,
  output logic [7:0]  pix_out,
  output logic        pix_out_valid,
  output logic        hsync,
  output logic        vsync,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun,
  output logic        overflow
);

  localparam int c_addr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w  = c_addr_w + 1;
  localparam int c_col_w  = $clog2(H_ACTIVE + 1);
  localparam int c_line_w = $clog2(V_ACTIVE + 1);
  localparam int c_blk_mx = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int c_blk_w  = $clog2(c_blk_mx + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_ACTIVE = 3'd2,
    S_HBLANK = 3'd3,
    S_VBLANK = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [c_col_w-1:0]    col_q, col_d;
  logic [c_line_w-1:0]   line_q, line_d;
  logic [c_blk_w-1:0]    blk_q, blk_d;
  logic [c_addr_w-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0]    count_q, count_d;
  logic [7:0]            mem_q [FIFO_DEPTH];
  logic [7:0]            pix_out_q, pix_out_d;
  logic                  pix_valid_q, pix_valid_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  frame_done_q, frame_done_d;
  logic                  underrun_q, underrun_d;
  logic                  overflow_q, overflow_d;

  logic [15:0]           w_shifted;
  logic [7:0]            w_scaled;
  logic                  w_empty, w_full, w_active, w_wr, w_rd, w_clr;

  // Scale then saturate: anything above 8 bits after the shift clips to 255.
  assign w_shifted = pix_in >> SHIFT;
  assign w_scaled  = (w_shifted > 16'd255) ? 8'hFF : w_shifted[7:0];

  assign w_empty  = (count_q == '0);
  assign w_full   = (count_q == c_cnt_w'(FIFO_DEPTH));
  assign w_active = (state_q == S_ACTIVE);
  assign w_wr     = pix_in_valid && !w_full;
  // An empty FIFO in ACTIVE suppresses the read; a same-cycle write into an
  // empty FIFO therefore cannot be read until the following cycle.
  assign w_rd     = w_active && !w_empty;
  assign w_clr    = (state_q == S_IDLE) && start;

  assign pause         = (count_q >= c_cnt_w'(FIFO_DEPTH - 2));
  assign busy          = (state_q != S_IDLE);
  assign pix_out       = pix_out_q;
  assign pix_out_valid = pix_valid_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign frame_done    = frame_done_q;
  assign underrun      = underrun_q;
  assign overflow      = overflow_q;

  // FIFO bookkeeping and output staging
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    if (w_wr && !w_rd)      count_d = count_q + 1'b1;
    else if (!w_wr && w_rd) count_d = count_q - 1'b1;

    pix_valid_d = w_active;
    hsync_d     = w_active && (col_q == '0);
    vsync_d     = w_active && (col_q == '0) && (line_q == '0);
    pix_out_d   = pix_out_q;
    if (w_active) pix_out_d = w_empty ? 8'h00 : mem_q[rd_ptr_q];

    // start clears the sticky flags; a new event in the same cycle still sets them
    underrun_d = (underrun_q && !w_clr) || (w_active && w_empty);
    overflow_d = (overflow_q && !w_clr) || (pix_in_valid && w_full);
  end

  // Frame timing FSM
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    line_d       = line_q;
    blk_d        = blk_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          col_d   = '0;
          line_d  = '0;
          blk_d   = '0;
        end
      end
      S_FILL: begin
        if (count_q >= c_cnt_w'(H_ACTIVE)) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (col_q == c_col_w'(H_ACTIVE - 1)) begin
          col_d   = '0;
          blk_d   = '0;
          state_d = S_HBLANK;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_HBLANK: begin
        if (blk_q == c_blk_w'(H_BLANK - 1)) begin
          blk_d = '0;
          if (line_q < c_line_w'(V_ACTIVE - 1)) begin
            line_d  = line_q + 1'b1;
            // A full line already buffered skips the FILL cycle so the
            // line gap stays exactly H_BLANK; otherwise wait in FILL.
            state_d = (count_q >= c_cnt_w'(H_ACTIVE)) ? S_ACTIVE : S_FILL;
          end else begin
            state_d = S_VBLANK;
          end
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end
      S_VBLANK: begin
        if (blk_q == c_blk_w'(V_BLANK - 1)) begin
          blk_d        = '0;
          line_d       = '0;
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      line_q       <= '0;
      blk_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pix_out_q    <= '0;
      pix_valid_q  <= 1'b0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      line_q       <= line_d;
      blk_q        <= blk_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pix_out_q    <= pix_out_d;
      pix_valid_q  <= pix_valid_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: reset empties the FIFO through the pointers/count.
  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wr_ptr_q] <= w_scaled;
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_display_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_display_out
// Purpose  : Self-checking bench for pixel_display_out. Expected pixels are
//            queued as stimulus is driven and popped when the DUT emits them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_display_out;

  localparam int H_BLANK = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pix_in = '0;
  logic        pix_in_valid = 1'b0;
  logic        pause;
  logic [7:0]  pix_out;
  logic        pix_out_valid, hsync, vsync, busy, frame_done, underrun, overflow;

  pixel_display_out dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pix_in        (pix_in),
    .pix_in_valid  (pix_in_valid),
    .pause         (pause),
    .pix_out       (pix_out),
    .pix_out_valid (pix_out_valid),
    .hsync         (hsync),
    .vsync         (vsync),
    .busy          (busy),
    .frame_done    (frame_done),
    .underrun      (underrun),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int valid_cnt = 0, hs_cnt = 0, vs_cnt = 0, fd_cnt = 0;
  int gap = 0;
  bit sb_en = 1'b0, gap_chk = 1'b0, seen_line = 1'b0;
  logic [7:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write, honouring pause (bounded wait).
  task automatic feed(input logic [15:0] v, input bit push, input logic [7:0] e);
    int n;
    n = 0;
    while (pause && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("pause_stuck", pause, 0);
    pix_in       = v;
    pix_in_valid = 1'b1;
    if (push) sb.push_back(e);
    tick();
    pix_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_out"}, pix_out, 0);
    check({tag, "_valid"}, pix_out_valid, 0);
    check({tag, "_hsync"}, hsync, 0);
    check({tag, "_vsync"}, vsync, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_pause"}, pause, 0);
  endtask

  // Output monitor / scoreboard consumer, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) fd_cnt++;
      if (hsync) begin
        hs_cnt++;
        check("hsync_with_valid", pix_out_valid, 1);
      end
      if (vsync) begin
        vs_cnt++;
        check("vsync_with_hsync", hsync, 1);
      end
      if (pix_out_valid) begin
        valid_cnt++;
        if (gap_chk && hsync && seen_line) check("line_gap", gap, H_BLANK);
        gap       = 0;
        seen_line = 1'b1;
        if (sb_en) begin
          check("sb_pending", sb.size() != 0, 1);
          if (sb.size() != 0) check("pix_out", pix_out, sb.pop_front());
        end
      end else begin
        gap++;
      end
    end
  end

  logic [15:0] sat_in  [10] = '{16'hFFFF, 16'h0FF0, 16'h0070, 16'h1000, 16'h0FF8,
                                16'h0FE0, 16'h0000, 16'h000F, 16'h0010, 16'h0020};
  logic [7:0]  sat_exp [10] = '{8'd255, 8'd255, 8'd7, 8'd255, 8'd255,
                                8'd254, 8'd0, 8'd0, 8'd1, 8'd2};

  initial begin
    int v0, h0, s0, f0;
    bit sdone;

    // ---------------- reset state
    repeat (2) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // ---------------- full frame, with start pulsed while a line is active
    v0 = valid_cnt; h0 = hs_cnt; s0 = vs_cnt; f0 = fd_cnt;
    seen_line = 1'b0;
    gap_chk   = 1'b1;
    sb_en     = 1'b1;
    sdone     = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int k = 0; k < 64; k++) begin
      // hsync visible now means the FSM is in ACTIVE, column 1
      if (!sdone && k >= 24 && hsync && !pause) begin
        start = 1'b1;
        sdone = 1'b1;
      end
      feed(16'(16 * k), 1'b1, 8'(k));
      start = 1'b0;
    end
    check("start_pulse_injected", sdone, 1);
    for (int i = 0; i < 400; i++) begin
      if (fd_cnt > f0) break;
      tick();
    end
    repeat (6) tick();
    check("frame_valid_count", valid_cnt - v0, 64);
    check("frame_hsync_count", hs_cnt - h0, 8);
    check("frame_vsync_count", vs_cnt - s0, 1);
    check("frame_done_count", fd_cnt - f0, 1);
    check("frame_underrun", underrun, 0);
    check("frame_overflow", overflow, 0);
    check("frame_idle_busy", busy, 0);
    check("frame_sb_empty", sb.size(), 0);
    gap_chk = 1'b0;

    // ---------------- saturation, then asynchronous reset mid-frame
    for (int i = 0; i < 10; i++) feed(sat_in[i], (i < 8), sat_exp[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_drain(100);
    repeat (5) tick();
    check("midframe_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    tick();
    rst = 1'b0;
    tick();

    // ---------------- backpressure and overflow, no start
    for (int j = 0; j < 17; j++) begin
      check("pause_vs_count", pause, (j >= 14));
      if (j == 16) check("overflow_before_drop", overflow, 0);
      pix_in       = 16'(16 * (j + 20));
      pix_in_valid = 1'b1;
      if (j < 16) sb.push_back(8'(j + 20));
      tick();
      pix_in_valid = 1'b0;
    end
    check("overflow_set", overflow, 1);
    check("pause_full", pause, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("overflow_cleared_by_start", overflow, 0);
    wait_drain(100);
    repeat (10) tick();
    check("bp_underrun", underrun, 0);
    check("bp_waiting_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // ---------------- starvation: FILL wait, then forced underrun
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) feed(16'(16 * (40 + i)), 1'b1, 8'(40 + i));
    wait_drain(60);
    v0 = valid_cnt;
    repeat (30) tick();
    check("fill_wait_no_valid", valid_cnt - v0, 0);
    check("fill_wait_busy", busy, 1);
    for (int i = 0; i < 8; i++) feed(16'(16 * (50 + i)), 1'b1, 8'(50 + i));
    wait_drain(60);
    sb_en = 1'b0;
    for (int i = 0; i < 8; i++) feed(16'(16 * (60 + i)), 1'b0, 8'd0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (hsync) break;
    end
    check("line2_hsync", hsync, 1);
    check("line2_first_pixel", pix_out, 60);
    check("underrun_before_force", underrun, 0);
    force dut.count_q = 5'd0;
    @(posedge clk);
    #1;
    release dut.count_q;
    @(negedge clk);
    check("underrun_valid", pix_out_valid, 1);
    check("underrun_pix_zero", pix_out, 0);
    check("underrun_flag", underrun, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
